// File: rtl/mem_compare_engine.sv
// mem_compare_engine: streams an address window out of two SRAM-style read
// ports (result memory A, golden memory B) and reports the mismatch count
// plus the address and data of the first mismatch.
// Optional build macro MEMCMP_MASK_EN adds a Mask input (captured on Go) that
// restricts which bits take part in the compare.
module mem_compare_engine #(
  parameter int unsigned A_WIDTH = 13,
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go,
  input  logic [A_WIDTH-1:0] First,
  input  logic [A_WIDTH-1:0] Last,
  input  logic               Stop_First,
`ifdef MEMCMP_MASK_EN
  input  logic [D_WIDTH-1:0] Mask,
`endif
  output logic [A_WIDTH-1:0] Addr,
  output logic               En,
  output logic               Rw,
  input  logic [D_WIDTH-1:0] A_Data,
  input  logic [D_WIDTH-1:0] B_Data,
  output logic               Busy,
  output logic               Done,
  output logic               Pass,
  output logic [A_WIDTH:0]   Err_Count,
  output logic               Err_Valid,
  output logic [A_WIDTH-1:0] Err_Addr,
  output logic [D_WIDTH-1:0] Err_A,
  output logic [D_WIDTH-1:0] Err_B
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [A_WIDTH-1:0] ADDR_ONE = {{(A_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [A_WIDTH:0]   CNT_ONE  = {{A_WIDTH{1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] addr_cnt;
  logic [A_WIDTH-1:0] last_r;
  logic               stop_r;
  logic               cmp_vld;
  logic [A_WIDTH-1:0] cmp_addr;
  logic [D_WIDTH-1:0] diff;
  logic               mismatch;
  logic               start;
`ifdef MEMCMP_MASK_EN
  logic [D_WIDTH-1:0] mask_r;
`endif

  // Compare stage decode, next-state selection and control outputs
  always_comb begin
    state_nxt = state;
`ifdef MEMCMP_MASK_EN
    diff      = (A_Data ^ B_Data) & mask_r;
`else
    diff      = A_Data ^ B_Data;
`endif
    mismatch  = cmp_vld && (diff != '0);
    start     = Go && ((state == S_IDLE) || (state == S_DONE));
    En        = (state == S_SCAN);
    Addr      = (state == S_SCAN) ? addr_cnt : '0;
    Rw        = 1'b0;
    Busy      = (state == S_SCAN) || (state == S_DRAIN);
    Done      = (state == S_DONE);
    Pass      = (state == S_DONE) && (Err_Count == '0);
    unique case (state)
      S_IDLE, S_DONE: if (Go) state_nxt = S_SCAN;
      // a stop-on-first-error hit wins over reaching the end of the window
      S_SCAN: begin
        if (stop_r && mismatch)      state_nxt = S_DONE;
        else if (addr_cnt == last_r) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Window capture, address counter, read pipeline and error capture
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addr_cnt  <= '0;
      last_r    <= '0;
      stop_r    <= 1'b0;
      cmp_vld   <= 1'b0;
      cmp_addr  <= '0;
      Err_Count <= '0;
      Err_Valid <= 1'b0;
      Err_Addr  <= '0;
      Err_A     <= '0;
      Err_B     <= '0;
`ifdef MEMCMP_MASK_EN
      mask_r    <= '0;
`endif
    end else if (start) begin
      addr_cnt  <= First;
      last_r    <= Last;
      stop_r    <= Stop_First;
      cmp_vld   <= 1'b0;
      Err_Count <= '0;
      Err_Valid <= 1'b0;
      Err_Addr  <= '0;
      Err_A     <= '0;
      Err_B     <= '0;
`ifdef MEMCMP_MASK_EN
      mask_r    <= Mask;
`endif
    end else begin
      if (state == S_SCAN) begin
        addr_cnt <= addr_cnt + ADDR_ONE;
        cmp_addr <= addr_cnt;
      end
      // the read issued in the cycle of a stopping mismatch is dropped here
      cmp_vld <= (state == S_SCAN) && (state_nxt != S_DONE);
      if (mismatch) begin
        Err_Count <= Err_Count + CNT_ONE;
        if (!Err_Valid) begin
          Err_Valid <= 1'b1;
          Err_Addr  <= cmp_addr;
          Err_A     <= A_Data;
          Err_B     <= B_Data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_compare_engine.sv
// tb_mem_compare_engine: directed bench for mem_compare_engine with two
// behavioural memories and a window-level reference model.
// Build with MEMCMP_MASK_EN defined to also exercise the Mask input.
module tb_mem_compare_engine;

  localparam int DEPTH = 8192;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Go = 1'b0;
  logic [12:0] First = '0;
  logic [12:0] Last = '0;
  logic        Stop_First = 1'b0;
`ifdef MEMCMP_MASK_EN
  logic [7:0]  Mask = 8'hFF;
`endif
  logic [12:0] Addr;
  logic        En, Rw, Busy, Done, Pass, Err_Valid;
  logic [7:0]  A_Data, B_Data, Err_A, Err_B;
  logic [13:0] Err_Count;
  logic [12:0] Err_Addr;

  mem_compare_engine #(.A_WIDTH(13), .D_WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .Go(Go), .First(First), .Last(Last),
    .Stop_First(Stop_First),
`ifdef MEMCMP_MASK_EN
    .Mask(Mask),
`endif
    .Addr(Addr), .En(En), .Rw(Rw), .A_Data(A_Data), .B_Data(B_Data),
    .Busy(Busy), .Done(Done), .Pass(Pass), .Err_Count(Err_Count),
    .Err_Valid(Err_Valid), .Err_Addr(Err_Addr), .Err_A(Err_A), .Err_B(Err_B)
  );

  always #5 Clk = ~Clk;

  // SRAM-style memories: one-cycle read latency
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  logic [7:0] a_q = '0, b_q = '0;
  always @(posedge Clk) begin
    if (En && !Rw) begin
      a_q <= mem_a[Addr];
      b_q <= mem_b[Addr];
    end
  end
  assign A_Data = a_q;
  assign B_Data = b_q;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window-level reference: which words mismatch, when the scan ends
  int         m_first, m_n, m_ncmp, m_done_k, m_en_last, m_fi;
  bit         mm [DEPTH];
  int         m_faddr;
  logic [7:0] m_fa, m_fb;

  task automatic build_model(input int first, input int last, input bit stop,
                             input logic [7:0] mask);
    int stop_i;
    m_first = first;
    m_n     = ((last - first) & (DEPTH - 1)) + 1;
    m_fi    = -1;
    stop_i  = -1;
    for (int i = 0; i < DEPTH; i++) mm[i] = 1'b0;
    for (int i = 0; i < m_n; i++) begin
      int a;
      a = (first + i) % DEPTH;
      mm[i] = ((mem_a[a] ^ mem_b[a]) & mask) != 8'h00;
      if (mm[i] && m_fi < 0) begin
        m_fi = i; m_faddr = a; m_fa = mem_a[a]; m_fb = mem_b[a];
      end
      if (stop && mm[i] && stop_i < 0) stop_i = i;
    end
    if (stop_i >= 0) begin
      m_ncmp    = stop_i + 1;
      m_done_k  = stop_i + 2;
      m_en_last = (stop_i + 1 < m_n - 1) ? stop_i + 1 : m_n - 1;
    end else begin
      m_ncmp    = m_n;
      m_done_k  = m_n + 1;
      m_en_last = m_n - 1;
    end
  endtask

  // Per-cycle compare against the model; k = rising edges since the Go edge
  bit chk_on = 1'b0;
  int k, exp_cnt, en_cycles, done_seen_k;
  int issued [$];

  always @(negedge Clk) begin
    if (chk_on) begin
      if (k >= 2 && (k - 2) < m_ncmp && mm[k-2]) exp_cnt++;
      chk("en", longint'(En), longint'(k <= m_en_last));
      if (k <= m_en_last) chk("addr", longint'(Addr), longint'((m_first + k) % DEPTH));
      chk("busy", longint'(Busy), longint'(k < m_done_k));
      chk("done", longint'(Done), longint'(k >= m_done_k));
      chk("rw", longint'(Rw), 0);
      chk("err_count", longint'(Err_Count), longint'(exp_cnt));
      chk("err_valid", longint'(Err_Valid), longint'(exp_cnt != 0));
      if (exp_cnt != 0) begin
        chk("err_addr", longint'(Err_Addr), longint'(m_faddr));
        chk("err_a", longint'(Err_A), longint'(m_fa));
        chk("err_b", longint'(Err_B), longint'(m_fb));
      end
      chk("pass", longint'(Pass), longint'(k >= m_done_k && exp_cnt == 0));
      if (En) begin
        en_cycles++;
        issued.push_back(int'(Addr));
      end
      if (Done && done_seen_k < 0) done_seen_k = k;
      k++;
    end
  end

  task automatic run_scan(input int first, input int last, input bit stop,
                          input logic [7:0] mask, input int glitch);
    build_model(first, last, stop, mask);
    @(negedge Clk);
    First = 13'(first); Last = 13'(last); Stop_First = stop;
`ifdef MEMCMP_MASK_EN
    Mask = mask;
`endif
    Go = 1'b1;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    k = 0; exp_cnt = 0; en_cycles = 0; done_seen_k = -1;
    issued.delete();
    chk_on = 1'b1;
    for (int c = 0; c < m_done_k + 3; c++) begin
      @(negedge Clk);
      #1;
      if (c == glitch) begin
        Go = 1'b1;
        First = 13'h0555;
      end else begin
        Go = 1'b0;
      end
    end
    Go = 1'b0;
    chk_on = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, longint'(Addr), 0);
    chk({tag, "_en"}, longint'(En), 0);
    chk({tag, "_rw"}, longint'(Rw), 0);
    chk({tag, "_busy"}, longint'(Busy), 0);
    chk({tag, "_done"}, longint'(Done), 0);
    chk({tag, "_pass"}, longint'(Pass), 0);
    chk({tag, "_cnt"}, longint'(Err_Count), 0);
    chk({tag, "_valid"}, longint'(Err_Valid), 0);
    chk({tag, "_eaddr"}, longint'(Err_Addr), 0);
    chk({tag, "_ea"}, longint'(Err_A), 0);
    chk({tag, "_eb"}, longint'(Err_B), 0);
  endtask

  initial begin
    bit saw12;
    for (int i = 0; i < DEPTH; i++) begin
      mem_b[i] = 8'((i * 37 + 11) & 8'hFF);
      mem_a[i] = mem_b[i];
    end

    #2;
    chk_all_zero("reset");
    @(negedge Clk);
    Rst = 1'b1;

    // identical memories, full scan
    run_scan(0, 8191, 1'b0, 8'hFF, -1);
    chk("t1_en_cycles", en_cycles, 8192);
    chk("t1_done_k", done_seen_k, 8193);
    chk("t1_pass", longint'(Pass), 1);
    chk("t1_cnt", longint'(Err_Count), 0);
    chk("t1_valid", longint'(Err_Valid), 0);

    // two differences, full scan
    mem_a[16'h0010] = 8'h3C;
    mem_b[16'h0010] = 8'h3D;
    mem_a[16'h1FFF] = mem_b[16'h1FFF] ^ 8'h55;
    run_scan(0, 8191, 1'b0, 8'hFF, -1);
    chk("t2_cnt", longint'(Err_Count), 2);
    chk("t2_eaddr", longint'(Err_Addr), 'h0010);
    chk("t2_ea", longint'(Err_A), 'h3C);
    chk("t2_eb", longint'(Err_B), 'h3D);
    chk("t2_pass", longint'(Pass), 0);

    // stop on first error
    run_scan(0, 8191, 1'b1, 8'hFF, -1);
    chk("t3_done_k", done_seen_k, 18);
    chk("t3_cnt", longint'(Err_Count), 1);
    chk("t3_eaddr", longint'(Err_Addr), 'h0010);
    saw12 = 1'b0;
    foreach (issued[j]) if (issued[j] == 'h0012) saw12 = 1'b1;
    chk("t3_read_0012", longint'(saw12), 0);

    // full depth via First == Last+1, wraps past the top address
    run_scan('h1000, 'h0FFF, 1'b0, 8'hFF, -1);
    chk("t6_en_cycles", en_cycles, 8192);
    chk("t6_cnt", longint'(Err_Count), 2);
    chk("t6_eaddr", longint'(Err_Addr), 'h1FFF);

    // single-word window
    run_scan('h0010, 'h0010, 1'b0, 8'hFF, -1);
    chk("t7_en_cycles", en_cycles, 1);
    chk("t7_done_k", done_seen_k, 2);
    chk("t7_cnt", longint'(Err_Count), 1);

    // wrapping window, Go pulsed mid-scan must be ignored
    mem_a[16'h0010] = mem_b[16'h0010];
    mem_a[16'h1FFF] = mem_b[16'h1FFF];
    mem_a[0] = mem_b[0] ^ 8'h01;
    mem_a[2] = mem_b[2] ^ 8'h80;
    run_scan('h1FFE, 'h0001, 1'b0, 8'hFF, 1);
    chk("t4_n_issued", issued.size(), 4);
    if (issued.size() == 4) begin
      chk("t4_issue0", issued[0], 'h1FFE);
      chk("t4_issue1", issued[1], 'h1FFF);
      chk("t4_issue2", issued[2], 'h0000);
      chk("t4_issue3", issued[3], 'h0001);
    end
    chk("t4_cnt", longint'(Err_Count), 1);
    chk("t4_eaddr", longint'(Err_Addr), 'h0000);
    chk("t4_ea", longint'(Err_A), 'h0A);
    chk("t4_eb", longint'(Err_B), 'h0B);

    // asynchronous reset in the middle of a scan
    @(negedge Clk);
    First = '0; Last = 13'h1FFF; Stop_First = 1'b0; Go = 1'b1;
    @(posedge Clk);
    #1;
    Go = 1'b0;
    repeat (256) @(posedge Clk);
    #1;
    chk("t5_pre_addr", longint'(Addr), 'h0100);
    chk("t5_pre_en", longint'(En), 1);
    Rst = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    @(negedge Clk);
    chk("t5_rst_en_hold", longint'(En), 0);
    @(negedge Clk);
    Rst = 1'b1;
    run_scan('h0020, 'h002F, 1'b0, 8'hFF, -1);
    chk("t5_cnt", longint'(Err_Count), 0);
    chk("t5_pass", longint'(Pass), 1);
    chk("t5_en_cycles", en_cycles, 16);

`ifdef MEMCMP_MASK_EN
    // masked-out LSB difference is not an error
    mem_a[0] = mem_b[0];
    mem_a[2] = mem_b[2];
    mem_a[16'h0010] = 8'h3C;
    mem_b[16'h0010] = 8'h3D;
    run_scan('h0008, 'h0020, 1'b0, 8'hFE, -1);
    chk("mask_pass", longint'(Pass), 1);
    chk("mask_cnt", longint'(Err_Count), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
